// File: rtl/trace_dump_ctrl.sv
// Retired-instruction trace dumper: on a capture request, streams PC, instruction
// and reg0..reg31 as tagged words. The optional drop counter is enabled by TRACE_DROP_CNT_EN.
module trace_dump_ctrl #(
  parameter int MAX_FRAMES = 2049
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        cap_req,
  input  logic [31:0] cap_pc,
  input  logic [31:0] cap_inst,
  output logic        cap_busy,
  output logic [4:0]  rf_raddr,
  input  logic [31:0] rf_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [5:0]  out_tag,
  output logic        done,
  output logic [15:0] drop_cnt
);

  localparam int FRAME_W = $clog2(MAX_FRAMES + 1);

  typedef enum logic [2:0] {IDLE, HDR_PC, HDR_INST, REGS, DONE} state_t;

  state_t             state, state_nxt;
  logic [FRAME_W-1:0] frame_cnt;
  logic [31:0]        inst_lat;
  logic [4:0]         reg_idx;
  logic               load;
  logic               last_word;
  logic               frame_last;

  // Output slot may be refilled when empty or when the sink takes the current word.
  assign load       = !out_valid || out_ready;
  assign last_word  = (out_tag == 6'd33);
  assign frame_last = (frame_cnt == FRAME_W'(MAX_FRAMES - 1));

  assign cap_busy = (state != IDLE);
  assign done     = (state == DONE);
  // reg_idx names the register whose word is loaded next; reg0 is read from HDR_INST.
  assign rf_raddr = (state == REGS) ? reg_idx : 5'd0;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (cap_req) state_nxt = HDR_PC;
      HDR_PC:   if (load) state_nxt = HDR_INST;
      HDR_INST: if (load) state_nxt = REGS;
      REGS:     if (load && last_word) state_nxt = frame_last ? DONE : IDLE;
      DONE:     state_nxt = DONE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
      inst_lat  <= '0;
      reg_idx   <= '0;
      frame_cnt <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (cap_req) begin
            inst_lat  <= cap_inst;
            out_valid <= 1'b1;
            out_data  <= cap_pc;
            out_tag   <= 6'd0;
          end
        end
        HDR_PC: begin
          if (load) begin
            out_data <= inst_lat;
            out_tag  <= 6'd1;
          end
        end
        HDR_INST: begin
          if (load) begin
            out_data <= rf_rdata;
            out_tag  <= 6'd2;
            reg_idx  <= 5'd1;
          end
        end
        REGS: begin
          if (load) begin
            if (last_word) begin
              out_valid <= 1'b0;
              frame_cnt <= frame_cnt + 1'b1;
              reg_idx   <= 5'd0;
            end else begin
              out_data <= rf_rdata;
              out_tag  <= out_tag + 6'd1;
              reg_idx  <= reg_idx + 5'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef TRACE_DROP_CNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] drop_q;

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      drop_q <= '0;
    end else if (cap_req && cap_busy) begin
      drop_q <= sat_inc(drop_q);
    end
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_trace_dump_ctrl.sv
// Directed bench for trace_dump_ctrl built with MAX_FRAMES=2; expected words come
// from a k*0x11 (+ base) register-file model and hand-picked constants.
module tb_trace_dump_ctrl;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        cap_req;
  logic [31:0] cap_pc;
  logic [31:0] cap_inst;
  logic        cap_busy;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [5:0]  out_tag;
  logic        done;
  logic [15:0] drop_cnt;

  logic [31:0] rf_base;

  int n_cmp = 0;
  int n_err = 0;
  int cycles;

`ifdef TRACE_DROP_CNT_EN
  localparam logic [31:0] DROP_UNIT = 32'd1;
`else
  localparam logic [31:0] DROP_UNIT = 32'd0;
`endif

  always #5 clk_in = ~clk_in;

  assign rf_rdata = rf_base + 32'(rf_raddr) * 32'h11;

  trace_dump_ctrl #(.MAX_FRAMES(2)) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .cap_req  (cap_req),
    .cap_pc   (cap_pc),
    .cap_inst (cap_inst),
    .cap_busy (cap_busy),
    .rf_raddr (rf_raddr),
    .rf_rdata (rf_rdata),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_tag  (out_tag),
    .done     (done),
    .drop_cnt (drop_cnt)
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // Pulse cap_req in IDLE and confirm the PC word appears one edge later.
  task automatic start(input logic [31:0] pc, input logic [31:0] inst);
    cap_pc   = pc;
    cap_inst = inst;
    cap_req  = 1'b1;
    tick();
    cap_req  = 1'b0;
    chk("start_valid", 32'(out_valid), 32'd1);
    chk("start_tag", 32'(out_tag), 32'd0);
    chk("start_data", out_data, pc);
    chk("start_raddr", 32'(rf_raddr), 32'd0);
  endtask

  // Walk one frame whose PC word is already valid; optional stall and drop pulses.
  task automatic run_frame(input logic [31:0] pc, input logic [31:0] inst,
                           input int stall_tag, input bit pulses, output int ncyc);
    logic [31:0] exp;
    ncyc = 0;
    for (int t = 0; t < 34; t++) begin
      exp = (t == 0) ? pc : (t == 1) ? inst : rf_base + 32'(t - 2) * 32'h11;
      if (t == stall_tag) begin
        out_ready = 1'b0;
        repeat (3) begin
          chk($sformatf("stall_tag%0d", t), 32'(out_tag), 32'(t));
          chk($sformatf("stall_data%0d", t), out_data, exp);
          tick();
          ncyc++;
        end
        out_ready = 1'b1;
      end
      chk($sformatf("valid%0d", t), 32'(out_valid), 32'd1);
      chk($sformatf("tag%0d", t), 32'(out_tag), 32'(t));
      chk($sformatf("data%0d", t), out_data, exp);
      chk($sformatf("busy%0d", t), 32'(cap_busy), 32'd1);
      if (pulses && (t == 1 || t == 20 || t == 33)) cap_req = 1'b1;
      tick();
      ncyc++;
      cap_req = 1'b0;
    end
  endtask

  initial begin
    reset     = 1'b0;
    cap_req   = 1'b1;
    cap_pc    = 32'h1234_5678;
    cap_inst  = 32'h0;
    out_ready = 1'b1;
    rf_base   = 32'h0;
    tick();
    tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_tag", 32'(out_tag), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(cap_busy), 32'd0);
    chk("rst_raddr", 32'(rf_raddr), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    cap_req = 1'b0;
    reset   = 1'b1;
    tick();

    // Basic frame, sink always ready.
    start(32'h0040_0000, 32'h3C01_0000);
    chk("drop_after_rst_req", 32'(drop_cnt), 32'd0);
    run_frame(32'h0040_0000, 32'h3C01_0000, -1, 1'b0, cycles);
    chk("f1_cycles", 32'(cycles), 32'd34);
    chk("f1_last_data", out_data, 32'h0000_020F);
    chk("f1_end_valid", 32'(out_valid), 32'd0);
    chk("f1_end_busy", 32'(cap_busy), 32'd0);
    chk("f1_end_done", 32'(done), 32'd0);

    // Backpressure on tag 5; second frame reaches MAX_FRAMES.
    start(32'h0040_0004, 32'h2421_0005);
    run_frame(32'h0040_0004, 32'h2421_0005, 5, 1'b0, cycles);
    chk("f2_cycles", 32'(cycles), 32'd37);
    chk("f2_done", 32'(done), 32'd1);
    chk("f2_busy", 32'(cap_busy), 32'd1);
    chk("f2_valid", 32'(out_valid), 32'd0);
    cap_req = 1'b1;
    tick();
    cap_req = 1'b0;
    chk("done_drop", 32'(drop_cnt), DROP_UNIT);
    repeat (3) tick();
    chk("done_no_valid", 32'(out_valid), 32'd0);
    chk("done_sticky", 32'(done), 32'd1);

    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("rst2_done", 32'(done), 32'd0);
    chk("rst2_drop", 32'(drop_cnt), 32'd0);
    chk("rst2_busy", 32'(cap_busy), 32'd0);

    // Drop pulses at tags 1, 20, 33; back-to-back restart; nonzero reg0.
    rf_base = 32'hA500_0000;
    start(32'h0040_0100, 32'h8C22_0000);
    run_frame(32'h0040_0100, 32'h8C22_0000, -1, 1'b1, cycles);
    chk("f3_cycles", 32'(cycles), 32'd34);
    chk("f3_valid", 32'(out_valid), 32'd0);
    chk("f3_drop", 32'(drop_cnt), DROP_UNIT * 32'd3);
    start(32'h0040_0200, 32'hAC23_0004);
    tick();
    chk("f4_tag1", 32'(out_tag), 32'd1);
    repeat (16) tick();
    chk("f4_tag17", 32'(out_tag), 32'd17);
    chk("f4_data17", out_data, 32'hA500_00FF);

    // Mid-frame reset discards the partial frame.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_tag", 32'(out_tag), 32'd0);
    chk("mid_rst_data", out_data, 32'd0);
    chk("mid_rst_raddr", 32'(rf_raddr), 32'd0);
    chk("mid_rst_drop", 32'(drop_cnt), 32'd0);
    start(32'h0040_0300, 32'h0000_000C);
    run_frame(32'h0040_0300, 32'h0000_000C, -1, 1'b0, cycles);
    chk("f5_done", 32'(done), 32'd0);
    chk("f5_busy", 32'(cap_busy), 32'd0);
    start(32'h0040_0304, 32'h0000_0000);
    run_frame(32'h0040_0304, 32'h0000_0000, -1, 1'b0, cycles);
    chk("f6_done", 32'(done), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/trace_dump_ctrl.md
TRACE_DUMP_CTRL -- requirements
Module: trace_dump_ctrl

Interface
REQ-001 Parameter MAX_FRAMES, default 2049, number of snapshot frames emitted before the block stops permanently.
REQ-002 clk_in  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 cap_req  input  1  one-cycle request to snapshot CPU state after an instruction retires.
REQ-005 cap_pc  input  32  PC of the retired instruction, sampled when cap_req is accepted.
REQ-006 cap_inst  input  32  instruction word, sampled with cap_pc.
REQ-007 cap_busy  output  1  high while a frame is in progress or the block is done.
REQ-008 rf_raddr  output  5  register-file debug read address.
REQ-009 rf_rdata  input  32  register-file debug read data; combinational from rf_raddr in the same cycle.
REQ-010 out_valid  output  1  output word valid.
REQ-011 out_ready  input  1  sink accepts the word when out_valid and out_ready are both high.
REQ-012 out_data  output  32  output word.
REQ-013 out_tag  output  6  word identifier: 0 = PC, 1 = instruction, 2..33 = reg0..reg31.
REQ-014 done  output  1  MAX_FRAMES frames have been fully emitted.
REQ-015 drop_cnt  output  16  number of cap_req pulses ignored.

Function
REQ-016 States: IDLE, HDR_PC, HDR_INST, REGS, DONE.
- IDLE -> HDR_PC on cap_req.
- HDR_PC -> HDR_INST on acceptance.
- HDR_INST -> REGS on acceptance.
- REGS -> IDLE, or -> DONE, on acceptance of reg31.
REQ-017 cap_req accepted only in IDLE: cap_pc/cap_inst latched; out_valid=1, out_data=PC, out_tag=0 at the next edge (latency 1).
REQ-018 Output registered: new word loaded only when out_valid=0 or out_ready=1; out_data/out_tag held stable while out_valid=1 and out_ready=0.
REQ-019 REGS: rf_raddr = current register index (0..31); rf_rdata captured into out_data in the cycle the word is loaded; index increments only on load.
REQ-020 With out_ready held high, one frame = 34 consecutive valid cycles, tags 0,1,2..33 in order, no gaps.
REQ-021 rf_raddr = 0 outside REGS.
REQ-022 reg0 word is the value read from the port, not forced to zero.
REQ-023 Frame counter increments on acceptance of tag 33.
- If the new count equals MAX_FRAMES: go to DONE; done=1 and cap_busy=1 until reset.
- Otherwise: return to IDLE; a cap_req in the next cycle is accepted.
REQ-024 cap_busy = (state != IDLE).
REQ-025 cap_req while cap_busy=1 (including in the same cycle as tag-33 acceptance, and in DONE) is ignored and increments drop_cnt; drop_cnt saturates at 16'hFFFF.
REQ-026 Frame counter wide enough for MAX_FRAMES; no wrap-around before DONE.

Reset
REQ-027 reset=0 at a rising edge, in any state including mid-frame:
- state=IDLE, out_valid=0, out_data=0, out_tag=0.
- rf_raddr=0, done=0, drop_cnt=0, frame counter=0, latched PC/instruction=0.
- A partial frame is discarded, not resumed.
REQ-028 cap_req sampled in a reset cycle is ignored and not counted.

Configuration
REQ-029 Macro TRACE_DROP_CNT_EN.
- Defined: drop_cnt counts per REQ-025.
- Undefined: drop_cnt is constant 0 and no counter register exists; all other behaviour is unchanged.

Verification
REQ-030 Reset release, then cap_req with pc=32'h00400000, inst=32'h3C010000, out_ready=1, regfile reg k = k*16'h11 -> 34 words on consecutive cycles: 00400000, 3C010000, 0, 11, ..., reg31=0000020F; tags 0..33; then cap_busy=0.
REQ-031 Same frame, out_ready low for 3 cycles while tag 5 is valid -> out_data=00000033 and tag 5 held for all 3 cycles; tag 6 follows after acceptance; total 37 cycles.
REQ-032 cap_req pulsed at tags 1, 20 and 33 (accept cycle) -> all three ignored, drop_cnt=3; cap_req one cycle after tag 33 -> new frame starts.
REQ-033 MAX_FRAMES=2, three spaced requests -> two frames emitted, done=1 after the second tag 33, third request dropped (drop_cnt=1), no further out_valid.
REQ-034 reset=0 for one cycle while tag 17 is valid -> next cycle out_valid=0 and done=0; a following cap_req restarts at tag 0.
REQ-035 TRACE_DROP_CNT_EN undefined, run REQ-032 stimulus -> drop_cnt=0 throughout; frame output identical to REQ-032.
